ccc_lock_sequencer: RTL
=======================

# ccc_lock_sequencer

Parametrised clock-domain bring-up block that sits directly downstream of a fabric CCC instance and is clocked by that CCC's global output. It synchronises and qualifies the CCC `LOCK` output and releases up to `NUM_CH` per-domain resets in a fixed sequence. It also generates a programmable clock-enable pulse per domain and counts lock-loss events. It replaces ad-hoc tying of `LOCK` to downstream resets.

## Interface
- `NUM_CH`, 4: number of reset/enable channels, 1..8.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before release, ≥2.
- `SEQ_GAP`, 16: cycles between successive channel reset releases, ≥1.
- `DIV_WIDTH`, 8: width of each channel's clock-enable divide ratio.
- `CLK  in  1`: CCC global clock (GL0); the only clock.
- `RST  in  1`: synchronous, active-high reset.
- `LOCK  in  1`: CCC lock, asynchronous to `CLK`.
- `SW_RST  in  1`: synchronous request to re-run the sequence.
- `DIV_RATIO  in  NUM_CH*DIV_WIDTH`: channel i ratio in bits [i*DIV_WIDTH +: DIV_WIDTH].
- `RST_OUT  out  NUM_CH`: per-channel active-high reset.
- `CLK_EN  out  NUM_CH`: per-channel single-cycle enable pulse.
- `READY  out  1`: all channels released.
- `LOCK_LOST_CNT  out  8`: saturating lock-loss counter.
- `STATE  out  2`: current state; 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN.

## Operation
- `LOCK` passes through a 2-FF synchroniser to `lock_s`. No other logic samples raw `LOCK`.
- **WAIT_LOCK**
  - `RST_OUT` all 1, `READY` 0.
  - When `lock_s`=1, go to STABLE with `stab_cnt`=0.
- **STABLE**
  - `stab_cnt` increments each cycle while `lock_s`=1.
  - If `lock_s`=0, return to WAIT_LOCK. `LOCK_LOST_CNT` is not incremented.
  - When `stab_cnt`==`LOCK_STABLE_CYCLES`-1, go to RELEASE. On that edge, deassert `RST_OUT[0]` and clear `gap_cnt`.
- **RELEASE**
  - `gap_cnt` counts to `SEQ_GAP`-1. On wrap, deassert the next channel's `RST_OUT`, in ascending index order.
  - On the edge that deasserts `RST_OUT[NUM_CH-1]`, go to RUN and set `READY`=1.
  - If `NUM_CH`=1, STABLE goes directly to RUN.
- **RUN**
  - Hold the released state.
- **Lock loss** (`lock_s`=0 in RELEASE or RUN):
  - Next edge sets all `RST_OUT`=1, `READY`=0, state WAIT_LOCK.
  - `LOCK_LOST_CNT` increments and saturates at 255.
- **SW_RST**=1 in any state other than WAIT_LOCK:
  - Same effect as lock loss, but `LOCK_LOST_CNT` is unchanged.
  - SW_RST takes priority over a simultaneous lock loss, so no increment occurs.
- **Dividers**, one per channel:
  - `div_cnt[i]` is held at 0 while `RST_OUT[i]`=1.
  - Otherwise it counts 0..R, where R is the latched ratio, and `CLK_EN[i]`=1 in the cycle `div_cnt[i]`==R.
  - R=0 gives `CLK_EN[i]` continuously 1 while released.
  - `DIV_RATIO` is sampled into R on release and at each wrap. Mid-period changes take effect at the next period.
- `CLK_EN[i]` is forced to 0 on the same edge that `RST_OUT[i]` reasserts.

## Timing
- **Reset:** `RST`=1 at an edge gives, after that edge:
  - `RST_OUT` all 1, `CLK_EN` 0, `READY` 0, `LOCK_LOST_CNT` 0, `STATE` 0.
  - Synchroniser flops, `stab_cnt`, `gap_cnt` and `div_cnt` all cleared.
  - `RST` overrides all other inputs, including mid-sequence.
- **Release latency:** let edge 1 be the first edge sampling `LOCK`=1, with `LOCK` held high.
  - `RST_OUT[0]` falls after edge `LOCK_STABLE_CYCLES`+3.
  - `RST_OUT[i]` falls i×`SEQ_GAP` edges later.
  - `READY` rises on the same edge as `RST_OUT[NUM_CH-1]` falls.
- **Loss latency:** first edge sampling `LOCK`=0 is edge 1.
  - `RST_OUT` all 1 and `READY`=0 after edge 3.
- **SW_RST latency:** sampled at edge n gives outputs in reset after edge n.
  - With `lock_s` still 1, STABLE is entered at edge n+1 and qualification restarts from 0.
- **First enable:** `CLK_EN[i]` first pulses R+1 cycles after `RST_OUT[i]` falls, then every R+1 cycles.

## Test plan
- **Nominal bring-up.** Setup: `NUM_CH`=3, `LOCK_STABLE_CYCLES`=16, `SEQ_GAP`=4; `RST` released, then `LOCK`=1 from edge 1.
  - `RST_OUT[0]` falls after edge 19, `[1]` after edge 23, `[2]` after edge 27.
  - `READY`=1 after edge 27; `STATE` reads 0→1→2→3.
- **Lock glitch.** `LOCK` high 10 cycles, low 5, then high.
  - No `RST_OUT` deasserts early; `LOCK_LOST_CNT` stays 0.
  - Release happens 19 edges after the second rise.
- **Lock loss in RUN.** Drop `LOCK` in RUN.
  - All `RST_OUT`=1 and `READY`=0 after edge 3; `LOCK_LOST_CNT`=1.
  - Re-assert `LOCK`: the full sequence repeats.
  - Repeat 260 losses: `LOCK_LOST_CNT`=255.
- **Divider.** `DIV_RATIO[0]`=3.
  - `CLK_EN[0]` pulses every 4 cycles, first pulse 4 cycles after `RST_OUT[0]` falls.
  - Change the ratio to 0 mid-period: old period completes, then `CLK_EN[0]` is constant 1.
- **SW_RST mid-RELEASE.** Assert `SW_RST` after channel 0 is released, with `LOCK` still asserted.
  - All resets reassert next edge; `LOCK_LOST_CNT` unchanged.
  - Re-release occurs `LOCK_STABLE_CYCLES`+1 edges after SW_RST.
  - Simultaneous lock loss with `SW_RST`: counter is not incremented.
- **`RST` during RUN.** Assert `RST` in RUN with `LOCK_LOST_CNT`=2.
  - All outputs return to reset values after one edge, including `LOCK_LOST_CNT`=0.

Source files
------------

// File: rtl/ccc_lock_sequencer_if.sv
// ----------------------------------------------------------------------------
// ccc_lock_sequencer_if
// Bundles the control, status and per-channel signals of ccc_lock_sequencer.
//   lock          : CCC lock, asynchronous to the sequencer clock
//   sw_rst        : request to re-run the bring-up sequence
//   div_ratio     : per-channel clock-enable ratio, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   rst_out       : per-channel active-high reset
//   clk_en        : per-channel single-cycle clock-enable pulse
//   ready         : all channels released
//   lock_lost_cnt : saturating count of lock-loss events
//   state         : 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
// master = the side that drives lock/sw_rst/div_ratio; slave = the sequencer.
// ----------------------------------------------------------------------------
interface ccc_lock_sequencer_if #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 8
);
    logic                        lock;
    logic                        sw_rst;
    logic [NUM_CH*DIV_WIDTH-1:0] div_ratio;
    logic [NUM_CH-1:0]           rst_out;
    logic [NUM_CH-1:0]           clk_en;
    logic                        ready;
    logic [7:0]                  lock_lost_cnt;
    logic [1:0]                  state;

    modport master (
        output lock, sw_rst, div_ratio,
        input  rst_out, clk_en, ready, lock_lost_cnt, state
    );

    modport slave (
        input  lock, sw_rst, div_ratio,
        output rst_out, clk_en, ready, lock_lost_cnt, state
    );
endinterface

// File: rtl/ccc_lock_sequencer.sv
// ----------------------------------------------------------------------------
// ccc_lock_sequencer
// Qualifies the CCC lock output and releases NUM_CH per-domain resets in
// ascending order, SEQ_GAP cycles apart, after LOCK_STABLE_CYCLES cycles of
// continuous synchronised lock. Each released channel gets a programmable
// clock-enable pulse. Lock losses after qualification are counted.
// Ports:
//   clk : CCC global clock, the only clock
//   rst : synchronous active-high reset, overrides everything
//   bus : ccc_lock_sequencer_if slave (lock, sw_rst, div_ratio in;
//         rst_out, clk_en, ready, lock_lost_cnt, state out)
// ----------------------------------------------------------------------------
module ccc_lock_sequencer #(
    parameter int NUM_CH             = 4,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SEQ_GAP            = 16,
    parameter int DIV_WIDTH          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ccc_lock_sequencer_if.slave   bus
);
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABLE    = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam int STAB_W = (LOCK_STABLE_CYCLES > 2) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int GAP_W  = $clog2(SEQ_GAP + 1);
    localparam int CH_W   = 4;

    logic              lock_meta_reg, lock_s_reg;
    logic [1:0]        state_reg, state_next;
    logic [STAB_W-1:0] stab_cnt_reg, stab_cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [CH_W-1:0]   ch_idx_reg, ch_idx_next;   // next channel to release
    logic [NUM_CH-1:0] rst_out_reg, rst_out_next;
    logic              ready_reg, ready_next;
    logic [7:0]        lost_cnt_reg, lost_cnt_next;
    logic [NUM_CH-1:0] clk_en_vec;

    // Two-flop synchroniser: nothing else looks at the raw lock input.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= bus.lock;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        stab_cnt_next = stab_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        ch_idx_next   = ch_idx_reg;
        rst_out_next  = rst_out_reg;
        ready_next    = ready_reg;
        lost_cnt_next = lost_cnt_reg;

        if (bus.sw_rst && (state_reg != ST_WAIT_LOCK)) begin
            // Software restart wins over a coincident lock loss: no count.
            state_next   = ST_WAIT_LOCK;
            rst_out_next = '1;
            ready_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_WAIT_LOCK: begin
                    rst_out_next = '1;
                    ready_next   = 1'b0;
                    if (lock_s_reg) begin
                        state_next    = ST_STABLE;
                        stab_cnt_next = '0;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s_reg) begin
                        // Lock never qualified, so this is not a lock loss.
                        state_next = ST_WAIT_LOCK;
                    end else if (stab_cnt_reg == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
                        rst_out_next[0] = 1'b0;
                        gap_cnt_next    = '0;
                        ch_idx_next     = CH_W'(1);
                        if (NUM_CH == 1) begin
                            state_next = ST_RUN;
                            ready_next = 1'b1;
                        end else begin
                            state_next = ST_RELEASE;
                        end
                    end else begin
                        stab_cnt_next = stab_cnt_reg + STAB_W'(1);
                    end
                end
                default: begin  // ST_RELEASE and ST_RUN
                    if (!lock_s_reg) begin
                        state_next   = ST_WAIT_LOCK;
                        rst_out_next = '1;
                        ready_next   = 1'b0;
                        if (lost_cnt_reg != 8'hFF) begin
                            lost_cnt_next = lost_cnt_reg + 8'd1;
                        end
                    end else if (state_reg == ST_RELEASE) begin
                        if (gap_cnt_reg == GAP_W'(SEQ_GAP - 1)) begin
                            gap_cnt_next = '0;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (ch_idx_reg == CH_W'(i)) begin
                                    rst_out_next[i] = 1'b0;
                                end
                            end
                            ch_idx_next = ch_idx_reg + CH_W'(1);
                            if (ch_idx_reg == CH_W'(NUM_CH - 1)) begin
                                state_next = ST_RUN;
                                ready_next = 1'b1;
                            end
                        end else begin
                            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_WAIT_LOCK;
            stab_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            ch_idx_reg   <= '0;
            rst_out_reg  <= '1;
            ready_reg    <= 1'b0;
            lost_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            stab_cnt_reg <= stab_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            ch_idx_reg   <= ch_idx_next;
            rst_out_reg  <= rst_out_next;
            ready_reg    <= ready_next;
            lost_cnt_reg <= lost_cnt_next;
        end
    end

    // Per-channel divider. While the channel is (or is about to be) in reset
    // the counter is held at 0 and the ratio tracks the input, so the value
    // in place at the release edge is the one used for the first period.
    // The enable is registered from the current count, so the first pulse
    // lands R+1 cycles after release and is killed on a reasserting edge.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_div
        logic [DIV_WIDTH-1:0] cnt_reg;
        logic [DIV_WIDTH-1:0] ratio_reg;
        logic                 en_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg   <= '0;
                ratio_reg <= '0;
                en_reg    <= 1'b0;
            end else if (rst_out_reg[gi] || rst_out_next[gi]) begin
                cnt_reg   <= '0;
                ratio_reg <= bus.div_ratio[gi*DIV_WIDTH +: DIV_WIDTH];
                en_reg    <= 1'b0;
            end else begin
                en_reg <= (cnt_reg == ratio_reg);
                if (cnt_reg == ratio_reg) begin
                    cnt_reg   <= '0;
                    ratio_reg <= bus.div_ratio[gi*DIV_WIDTH +: DIV_WIDTH];
                end else begin
                    cnt_reg <= cnt_reg + DIV_WIDTH'(1);
                end
            end
        end

        assign clk_en_vec[gi] = en_reg;
    end

    assign bus.rst_out       = rst_out_reg;
    assign bus.clk_en        = clk_en_vec;
    assign bus.ready         = ready_reg;
    assign bus.lock_lost_cnt = lost_cnt_reg;
    assign bus.state         = state_reg;
endmodule
